// File: rtl/alu_vector_sequencer.sv
// alu_vector_sequencer
//   Holds up to DEPTH operand/control vectors and walks an external ALU
//   through load_a -> load_b -> mux for each one. The ALU result and flags
//   are captured per vector, compared with stored expected values under a
//   per-flag mask, and summarised in saturating pass/fail counters plus the
//   index of the first mismatch. Runs are single-pass or continuous-loop.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   vec_we/vec_addr/vec_*      vector entry write port (IDLE only)
//   vec_count, loop_mode       run length and mode, sampled on start
//   start, stop                begin run / request end of run
//   op, alu_ctrl               operand and control word driven to the ALU
//   load_a, load_b,
//   load_b_from_bs,
//   load_b_from_muxa, mux      ALU phase strobes
//   result, carry,
//   halfcarry, zero            ALU outputs, captured at the end of MUX
//   busy, done                 run in progress / one-cycle end-of-run pulse
//   res_addr -> res_data,
//   res_flags, res_ok,
//   res_valid                  combinational per-entry result readback
//   pass_count, fail_count     saturating run statistics
//   fail_seen, first_fail_idx  first-mismatch tracking
module alu_vector_sequencer #(
    parameter int WIDTH  = 8,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vec_we,
    input  logic [AW-1:0]     vec_addr,
    input  logic [WIDTH-1:0]  vec_a,
    input  logic [WIDTH-1:0]  vec_b,
    input  logic [CTRL_W-1:0] vec_ctrl,
    input  logic [WIDTH-1:0]  vec_exp,
    input  logic [2:0]        vec_exp_flags,
    input  logic [2:0]        vec_flag_mask,
    input  logic [AW:0]       vec_count,
    input  logic              start,
    input  logic              loop_mode,
    input  logic              stop,
    output logic [WIDTH-1:0]  op,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              load_a,
    output logic              load_b,
    output logic              load_b_from_bs,
    output logic              load_b_from_muxa,
    output logic              mux,
    input  logic [WIDTH-1:0]  result,
    input  logic              carry,
    input  logic              halfcarry,
    input  logic              zero,
    output logic              busy,
    output logic              done,
    input  logic [AW-1:0]     res_addr,
    output logic [WIDTH-1:0]  res_data,
    output logic [2:0]        res_flags,
    output logic              res_ok,
    output logic              res_valid,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              fail_seen,
    output logic [AW-1:0]     first_fail_idx
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_MUX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // Vector and result storage; deliberately not reset.
    logic [WIDTH-1:0]  mem_a     [DEPTH];
    logic [WIDTH-1:0]  mem_b     [DEPTH];
    logic [CTRL_W-1:0] mem_ctrl  [DEPTH];
    logic [WIDTH-1:0]  mem_exp   [DEPTH];
    logic [2:0]        mem_eflg  [DEPTH];
    logic [2:0]        mem_mask  [DEPTH];
    logic [WIDTH-1:0]  mem_res   [DEPTH];
    logic [2:0]        mem_rflg  [DEPTH];
    logic              mem_ok    [DEPTH];

    logic [DEPTH-1:0]  valid_bits;
    logic [AW-1:0]     idx;
    logic [AW:0]       count_q;
    logic              loop_q;
    logic              stop_q;

    logic [2:0]        flags_in;
    logic              match;
    logic              last;
    logic              stop_pend;
    logic              run_go;
    logic [AW:0]       count_in;

    assign flags_in  = {zero, halfcarry, carry};
    assign match     = (result == mem_exp[idx]) &&
                       (((flags_in ^ mem_eflg[idx]) & mem_mask[idx]) == 3'b000);
    assign last      = ({1'b0, idx} == (count_q - 1'b1));
    // A stop raised during the MUX cycle itself still ends the run there.
    assign stop_pend = stop_q | stop;
    assign run_go    = (state == S_IDLE) && start && (vec_count != '0);
    assign count_in  = (vec_count > DEPTH_C) ? DEPTH_C : vec_count;

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = (vec_count == '0) ? S_DONE : S_LOAD_A;
            S_LOAD_A: state_nx = S_LOAD_B;
            S_LOAD_B: state_nx = S_MUX;
            S_MUX:    state_nx = (stop_pend || (last && !loop_q)) ? S_DONE : S_LOAD_A;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state so they drop as soon as reset hits.
    always_comb begin
        op               = '0;
        alu_ctrl         = '0;
        load_a           = 1'b0;
        load_b           = 1'b0;
        load_b_from_bs   = 1'b0;
        load_b_from_muxa = 1'b0;
        mux              = 1'b0;
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        case (state)
            S_LOAD_A: begin
                op       = mem_a[idx];
                alu_ctrl = mem_ctrl[idx];
                load_a   = 1'b1;
            end
            S_LOAD_B: begin
                op               = mem_b[idx];
                alu_ctrl         = mem_ctrl[idx];
                load_b           = 1'b1;
                load_b_from_bs   = mem_ctrl[idx][0];
                load_b_from_muxa = mem_ctrl[idx][1];
            end
            S_MUX: begin
                op       = mem_b[idx];
                alu_ctrl = mem_ctrl[idx];
                mux      = 1'b1;
            end
            default: ;
        endcase
    end

    // Control and statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            count_q        <= '0;
            loop_q         <= 1'b0;
            stop_q         <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            valid_bits     <= '0;
        end else begin
            state <= state_nx;
            if (run_go) begin
                idx            <= '0;
                count_q        <= count_in;
                loop_q         <= loop_mode;
                stop_q         <= stop;
                pass_count     <= '0;
                fail_count     <= '0;
                fail_seen      <= 1'b0;
                first_fail_idx <= '0;
                valid_bits     <= '0;
            end else if (state != S_IDLE) begin
                stop_q <= stop_q | stop;
            end

            if (state == S_MUX) begin
                valid_bits[idx] <= 1'b1;
                if (!match) begin
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    if (!fail_seen) begin
                        fail_seen      <= 1'b1;
                        first_fail_idx <= idx;
                    end
                end
                if (last) begin
                    if (pass_count != '1) pass_count <= pass_count + 1'b1;
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Vector writes and result capture
    always_ff @(posedge clk) begin
        if (state == S_IDLE && vec_we) begin
            mem_a[vec_addr]    <= vec_a;
            mem_b[vec_addr]    <= vec_b;
            mem_ctrl[vec_addr] <= vec_ctrl;
            mem_exp[vec_addr]  <= vec_exp;
            mem_eflg[vec_addr] <= vec_exp_flags;
            mem_mask[vec_addr] <= vec_flag_mask;
        end
        if (state == S_MUX) begin
            mem_res[idx]  <= result;
            mem_rflg[idx] <= flags_in;
            mem_ok[idx]   <= match;
        end
    end

    assign res_data  = mem_res[res_addr];
    assign res_flags = mem_rflg[res_addr];
    assign res_ok    = mem_ok[res_addr];
    assign res_valid = valid_bits[res_addr];

endmodule

// File: tb/tb_alu_vector_sequencer.sv
module tb_alu_vector_sequencer;

    localparam int W     = 8;
    localparam int CW    = 16;
    localparam int D     = 8;
    localparam int CNTW  = 4;
    localparam int AW    = 3;
    localparam int OBS_W = 5 + CW + W;
    localparam int SAT   = (1 << CNTW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          vec_we;
    logic [AW-1:0] vec_addr;
    logic [W-1:0]  vec_a, vec_b, vec_exp;
    logic [CW-1:0] vec_ctrl;
    logic [2:0]    vec_exp_flags, vec_flag_mask;
    logic [AW:0]   vec_count;
    logic          start, loop_mode, stop;
    logic [W-1:0]  op;
    logic [CW-1:0] alu_ctrl;
    logic          load_a, load_b, load_b_from_bs, load_b_from_muxa, mux;
    logic [W-1:0]  result;
    logic          carry, halfcarry, zero;
    logic          busy, done;
    logic [AW-1:0] res_addr;
    logic [W-1:0]  res_data;
    logic [2:0]    res_flags;
    logic          res_ok, res_valid;
    logic [CNTW-1:0] pass_count, fail_count;
    logic          fail_seen;
    logic [AW-1:0] first_fail_idx;

    int errors = 0;
    int checks = 0;

    alu_vector_sequencer #(.WIDTH(W), .CTRL_W(CW), .DEPTH(D), .CNT_W(CNTW)) dut (
        .clk(clk), .reset(reset),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_a(vec_a), .vec_b(vec_b),
        .vec_ctrl(vec_ctrl), .vec_exp(vec_exp), .vec_exp_flags(vec_exp_flags),
        .vec_flag_mask(vec_flag_mask), .vec_count(vec_count),
        .start(start), .loop_mode(loop_mode), .stop(stop),
        .op(op), .alu_ctrl(alu_ctrl), .load_a(load_a), .load_b(load_b),
        .load_b_from_bs(load_b_from_bs), .load_b_from_muxa(load_b_from_muxa), .mux(mux),
        .result(result), .carry(carry), .halfcarry(halfcarry), .zero(zero),
        .busy(busy), .done(done),
        .res_addr(res_addr), .res_data(res_data), .res_flags(res_flags),
        .res_ok(res_ok), .res_valid(res_valid),
        .pass_count(pass_count), .fail_count(fail_count),
        .fail_seen(fail_seen), .first_fail_idx(first_fail_idx)
    );

    // ---------------- emulated ALU ----------------
    // Returns {zero, halfcarry, carry, result}; ctrl[3:2] picks add/and/xor/sub.
    function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [CW-1:0] c);
        logic [W:0]   s;
        logic [4:0]   h;
        logic [W-1:0] r;
        logic         cy, hc;
        s = '0; h = '0; r = '0; cy = 1'b0; hc = 1'b0;
        case (c[3:2])
            2'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                h  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                r  = s[W-1:0];
                cy = s[W];
                hc = h[4];
            end
            2'd1: r = a & b;
            2'd2: r = a ^ b;
            default: begin
                r  = a - b;
                cy = (a < b);
                hc = (a[3:0] < b[3:0]);
            end
        endcase
        return {(r == '0), hc, cy, r};
    endfunction

    logic [W-1:0] alu_a = '0;
    logic [W-1:0] alu_b = '0;
    always @(negedge clk) begin
        if (load_a) alu_a <= op;
        if (load_b) alu_b <= op;
    end
    always_comb {zero, halfcarry, carry, result} = alu_fn(alu_a, alu_b, alu_ctrl);

    // ---------------- strobe monitor ----------------
    logic [OBS_W-1:0] obs_q[$];
    logic [OBS_W-1:0] exp_q[$];
    int la_cnt = 0;
    always @(negedge clk) begin
        if (load_a || load_b || mux)
            obs_q.push_back({load_a, load_b, mux, load_b_from_bs, load_b_from_muxa, alu_ctrl, op});
        if (load_a) la_cnt <= la_cnt + 1;
    end

    // ---------------- vector mirrors ----------------
    logic [W-1:0]  va[D], vb[D], ve[D];
    logic [CW-1:0] vc[D];
    logic [2:0]    vf[D], vm[D];

    // ---------------- driver tasks ----------------
    task automatic write_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [CW-1:0] c, input logic [W-1:0] e,
                             input logic [2:0] f, input logic [2:0] m);
        @(negedge clk);
        vec_we = 1'b1; vec_addr = AW'(i);
        vec_a = a; vec_b = b; vec_ctrl = c; vec_exp = e;
        vec_exp_flags = f; vec_flag_mask = m;
        va[i] = a; vb[i] = b; vc[i] = c; ve[i] = e; vf[i] = f; vm[i] = m;
        @(negedge clk);
        vec_we = 1'b0;
    endtask

    // bad_pct: chance that an entry's expected result is corrupted.
    task automatic write_rand(input int bad_pct);
        logic [W-1:0]  a, b, e;
        logic [CW-1:0] c;
        logic [W+2:0]  r;
        logic [2:0]    f;
        for (int i = 0; i < D; i++) begin
            a = W'($urandom); b = W'($urandom); c = CW'($urandom);
            r = alu_fn(a, b, c);
            e = r[W-1:0];
            if ($urandom_range(0, 99) < bad_pct) e = e ^ W'($urandom_range(1, 255));
            f = r[W+2:W];
            if ($urandom_range(0, 3) == 0) f = f ^ 3'($urandom);
            write_vec(i, a, b, c, e, f, 3'($urandom));
        end
    endtask

    // Start a run, optionally raise stop when the stop_at'th vector loads
    // (or together with start), then score everything against the model.
    task automatic run_check(input int cnt, input bit loop, input int stop_at,
                             input bit stop_with_start, input bit poke, input string name);
        int n, total, passes, fails, ff, la0, ob0, got_n, i;
        bit seen_done;
        bit exp_valid[D];
        logic [W+2:0] r;
        logic ok;

        n   = (cnt > D) ? D : cnt;
        la0 = la_cnt;
        ob0 = obs_q.size();
        @(negedge clk);
        vec_count = (AW+1)'(cnt); loop_mode = loop; start = 1'b1; stop = stop_with_start;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            #1;
            if (done) begin seen_done = 1'b1; break; end
            stop = (!stop_with_start && stop_at > 0 && (la_cnt - la0) == stop_at && load_a);
            if (poke) begin
                vec_we = 1'b1; vec_addr = '0; vec_a = ~va[0]; vec_b = vb[0];
                vec_ctrl = vc[0]; vec_exp = ~ve[0]; vec_exp_flags = vf[0];
                vec_flag_mask = vm[0]; start = 1'b1; vec_count = 1; loop_mode = 1'b1;
            end
            @(negedge clk);
        end
        stop = 1'b0; start = 1'b0; vec_we = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s_timeout: done never seen, required within 500 cycles", name);
        end
        @(negedge clk);

        // Reference model
        if (stop_with_start)                 total = 1;
        else if (loop)                       total = stop_at;
        else if (stop_at > 0 && stop_at < n) total = stop_at;
        else                                 total = n;
        passes = total / n;
        fails  = 0;
        ff     = -1;
        exp_q.delete();
        for (int k = 0; k < D; k++) exp_valid[k] = 1'b0;
        for (int k = 0; k < total; k++) begin
            i = k % n;
            r = alu_fn(va[i], vb[i], vc[i]);
            ok = (r[W-1:0] == ve[i]) && (((r[W+2:W] ^ vf[i]) & vm[i]) == 3'b000);
            if (!ok) begin
                fails++;
                if (ff < 0) ff = i;
            end
            exp_valid[i] = 1'b1;
            exp_q.push_back({3'b100, 2'b00, vc[i], va[i]});
            exp_q.push_back({3'b010, vc[i][0], vc[i][1], vc[i], vb[i]});
            exp_q.push_back({3'b001, 2'b00, vc[i], vb[i]});
        end

        got_n = obs_q.size() - ob0;
        checks++;
        if (got_n != exp_q.size()) begin
            errors++;
            $display("FAIL %s_phase_count: got %0d phases, required %0d", name, got_n, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_n; k++) begin
            checks++;
            if (obs_q[ob0 + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s_phase[%0d]: got %h required %h", name, k, obs_q[ob0 + k], exp_q[k]);
            end
        end

        checks++;
        if (pass_count !== CNTW'(passes > SAT ? SAT : passes)) begin
            errors++;
            $display("FAIL %s_pass_count: got %0d required %0d", name, pass_count, passes > SAT ? SAT : passes);
        end
        checks++;
        if (fail_count !== CNTW'(fails > SAT ? SAT : fails)) begin
            errors++;
            $display("FAIL %s_fail_count: got %0d required %0d", name, fail_count, fails > SAT ? SAT : fails);
        end
        checks++;
        if (fail_seen !== (ff >= 0)) begin
            errors++;
            $display("FAIL %s_fail_seen: got %0b required %0b", name, fail_seen, ff >= 0);
        end
        checks++;
        if (first_fail_idx !== AW'(ff < 0 ? 0 : ff)) begin
            errors++;
            $display("FAIL %s_first_fail_idx: got %0d required %0d", name, first_fail_idx, ff < 0 ? 0 : ff);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got %0b required 0", name, busy);
        end

        for (int k = 0; k < D; k++) begin
            res_addr = AW'(k);
            #1;
            checks++;
            if (res_valid !== exp_valid[k]) begin
                errors++;
                $display("FAIL %s_res_valid[%0d]: got %0b required %0b", name, k, res_valid, exp_valid[k]);
            end
            if (exp_valid[k]) begin
                r  = alu_fn(va[k], vb[k], vc[k]);
                ok = (r[W-1:0] == ve[k]) && (((r[W+2:W] ^ vf[k]) & vm[k]) == 3'b000);
                checks++;
                if (res_data !== r[W-1:0] || res_flags !== r[W+2:W] || res_ok !== ok) begin
                    errors++;
                    $display("FAIL %s_res[%0d]: got data=%h flags=%b ok=%b required data=%h flags=%b ok=%b",
                             name, k, res_data, res_flags, res_ok, r[W-1:0], r[W+2:W], ok);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, load_a, load_b, load_b_from_bs, load_b_from_muxa, mux} !== 7'b0 ||
            op !== '0 || alu_ctrl !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b op=%h ctrl=%h, required all 0",
                     busy, done, op, alu_ctrl);
        end
        checks++;
        if (pass_count !== '0 || fail_count !== '0 || fail_seen !== 1'b0 || first_fail_idx !== '0) begin
            errors++;
            $display("FAIL reset_counters: got pass=%0d fail=%0d seen=%b ffi=%0d, required 0",
                     pass_count, fail_count, fail_seen, first_fail_idx);
        end
        for (int k = 0; k < D; k++) begin
            res_addr = AW'(k);
            #1;
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_res_valid[%0d]: got %b required 0", k, res_valid);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        // 0x3C + 0x0F = 0x4B, nibble carry set, no carry, nonzero.
        write_vec(0, 8'h3C, 8'h0F, 16'h0000, 8'h4B, 3'b010, 3'b111);
        @(negedge clk);
        vec_count = 1; loop_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (load_a !== 1'b1 || op !== 8'h3C || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_cycle1: got load_a=%b op=%h, required 1 3c", load_a, op);
        end
        @(negedge clk);
        checks++;
        if (load_b !== 1'b1 || load_a !== 1'b0 || op !== 8'h0F) begin
            errors++;
            $display("FAIL single_cycle2: got load_b=%b op=%h, required 1 0f", load_b, op);
        end
        @(negedge clk);
        checks++;
        if (mux !== 1'b1 || op !== 8'h0F) begin
            errors++;
            $display("FAIL single_cycle3: got mux=%b op=%h, required 1 0f", mux, op);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || mux !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle4: got done=%b busy=%b, required 1 1", done, busy);
        end
        @(negedge clk);
        res_addr = '0;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass_count !== 4'd1 || fail_count !== 4'd0 ||
            res_valid !== 1'b1 || res_data !== 8'h4B || res_ok !== 1'b1) begin
            errors++;
            $display("FAIL single_after: got done=%b busy=%b pass=%0d fail=%0d valid=%b data=%h ok=%b, required 0 0 1 0 1 4b 1",
                     done, busy, pass_count, fail_count, res_valid, res_data, res_ok);
        end
    endtask

    task automatic test_mismatch();
        write_vec(0, 8'h10, 8'h20, 16'h0000, 8'h30, 3'b000, 3'b111);
        write_vec(1, 8'hF0, 8'h0F, 16'h0004, 8'h00, 3'b100, 3'b111);
        write_vec(2, 8'hAA, 8'h00, 16'h0000, 8'h55, 3'b000, 3'b000);
        write_vec(3, 8'h05, 8'h03, 16'h000C, 8'h02, 3'b000, 3'b111);
        run_check(4, 1'b0, 0, 1'b0, 1'b0, "mismatch");
        checks++;
        if (fail_count !== 4'd1 || first_fail_idx !== 3'd2) begin
            errors++;
            $display("FAIL mismatch_direct: got fail=%0d ffi=%0d, required 1 2", fail_count, first_fail_idx);
        end
    endtask

    task automatic test_flag_mask();
        write_vec(0, 8'h01, 8'h01, 16'h0000, 8'h02, 3'b001, 3'b000);
        run_check(1, 1'b0, 0, 1'b0, 1'b0, "mask_off");
        write_vec(0, 8'h01, 8'h01, 16'h0000, 8'h02, 3'b001, 3'b001);
        run_check(1, 1'b0, 0, 1'b0, 1'b0, "mask_on");
        checks++;
        if (fail_count !== 4'd1) begin
            errors++;
            $display("FAIL mask_on_direct: got fail=%0d required 1", fail_count);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            write_rand(30);
            run_check(int'($urandom_range(1, D)), 1'b0, 0, 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_loop_stop();
        write_rand(20);
        // pass 3, index 5 is vector number 2*8+6
        run_check(8, 1'b1, 22, 1'b0, 1'b0, "loop_stop");
        checks++;
        if (pass_count !== 4'd2) begin
            errors++;
            $display("FAIL loop_stop_direct: got pass=%0d required 2", pass_count);
        end
    endtask

    task automatic test_saturation();
        logic [W+2:0] r;
        for (int i = 0; i < D; i++) begin
            r = alu_fn(8'(i * 17), 8'(i + 3), 16'h0000);
            write_vec(i, 8'(i * 17), 8'(i + 3), 16'h0000, r[W-1:0] ^ 8'h01, 3'b000, 3'b000);
        end
        run_check(8, 1'b1, 24, 1'b0, 1'b0, "sat_fail");
        run_check(1, 1'b1, 20, 1'b0, 1'b0, "sat_pass");
    endtask

    task automatic test_edge_counts();
        int ob0;
        ob0 = obs_q.size();
        @(negedge clk);
        vec_count = 0; loop_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL count0_done: got done=%b busy=%b required 1 1", done, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || obs_q.size() != ob0) begin
            errors++;
            $display("FAIL count0_after: got done=%b busy=%b strobes=%0d required 0 0 0",
                     done, busy, obs_q.size() - ob0);
        end
        write_rand(25);
        run_check(D + 3, 1'b0, 0, 1'b0, 1'b0, "count_clamp");
        run_check(D, 1'b0, 0, 1'b0, 1'b1, "busy_ignore");
        run_check(1, 1'b0, 0, 1'b0, 1'b0, "busy_ignore_recheck");
    endtask

    task automatic test_simul_start_stop();
        write_rand(25);
        run_check(D, 1'b1, 0, 1'b1, 1'b0, "start_stop");
    endtask

    task automatic test_reset_mid();
        int la0;
        bit hit;
        write_rand(60);
        la0 = la_cnt;
        @(negedge clk);
        vec_count = D; loop_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if ((la_cnt - la0) >= 4 && load_b) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: load_b of vector 3 not seen, required within 100 cycles");
        end
        reset = 1'b1;
        res_addr = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || load_b !== 1'b0 || op !== '0 || pass_count !== '0 ||
            fail_count !== '0 || fail_seen !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b load_b=%b op=%h pass=%0d fail=%0d seen=%b valid=%b, required all 0",
                     busy, load_b, op, pass_count, fail_count, fail_seen, res_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        run_check(D, 1'b0, 0, 1'b0, 1'b0, "after_reset");
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1; vec_we = 1'b0; vec_addr = '0; vec_a = '0; vec_b = '0;
        vec_ctrl = '0; vec_exp = '0; vec_exp_flags = '0; vec_flag_mask = '0;
        vec_count = '0; start = 1'b0; loop_mode = 1'b0; stop = 1'b0; res_addr = '0;
        test_reset();
        test_single();
        test_mismatch();
        test_flag_mask();
        test_random();
        test_loop_stop();
        test_saturation();
        test_edge_counts();
        test_simul_start_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
